// File: rtl/serdes_link_pkg.sv
// Link-layer constants shared by the transmit framer and the receive-side aligner:
// control nibbles, training pattern, link state encoding and the frame check nibble.
package serdes_link_pkg;

   localparam logic [3:0] SOF_NIB  = 4'h6;
   localparam logic [3:0] IDLE_NIB = 4'hA;

   // Training pattern, first nibble in the top position
   localparam logic [15:0] TRAIN_TBL = 16'hF0C3;

   typedef enum logic [2:0] {
      ST_DOWN,
      ST_TRAIN,
      ST_IDLE,
      ST_SOF,
      ST_DATA,
      ST_CHK
   } link_state_e;

   function automatic logic [3:0] train_nibble(input logic [1:0] idx);
      logic [3:0] nib;
      case (idx)
         2'd0:    nib = TRAIN_TBL[15:12];
         2'd1:    nib = TRAIN_TBL[11:8];
         2'd2:    nib = TRAIN_TBL[7:4];
         default: nib = TRAIN_TBL[3:0];
      endcase
      return nib;
   endfunction

   function automatic logic [3:0] chk_nibble(input logic [15:0] w);
      return w[15:12] ^ w[11:8] ^ w[7:4] ^ w[3:0];
   endfunction

endpackage

// File: rtl/serdes_tx_framer.sv
// Transmit framer: trains the link, then wraps 16-bit words as SOF + 4 data nibbles + XOR check.
// One nibble per sclk, all outputs registered; back-to-back words run at one frame per 6 cycles.
module serdes_tx_framer
   import serdes_link_pkg::*;
#(
   parameter int TRAIN_LEN = 256
) (
   input  logic        sclk,
   input  logic        reset,
   input  logic        tx_start,
   input  logic        train,
   input  logic [15:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic [3:0]  txd,
   output logic        tx_ready
);

   localparam int             CW       = $clog2(TRAIN_LEN);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TRAIN_LEN - 1);
   localparam logic [CW-1:0]  CNT_WRAP = CW'(TRAIN_LEN - 4);

   logic [1:0]    rst_sync_q, rst_sync_d;
   logic          rst_int;

   link_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0]   data_q, data_d;
   logic          train_pend_q, train_pend_d;
   logic [3:0]    txd_q, txd_d;
   logic          tx_ready_q, tx_ready_d;
   logic          din_ready_q, din_ready_d;
   logic          xfer;

   // Reset asserts immediately, releases two sclk edges later
   always_comb rst_sync_d = {rst_sync_q[0], 1'b0};

   always_ff @(posedge sclk or posedge reset) begin
      if (reset) rst_sync_q <= 2'b11;
      else       rst_sync_q <= rst_sync_d;
   end

   assign rst_int = rst_sync_q[1];
   assign xfer    = din_valid & din_ready_q;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      // A train request seen mid-frame is remembered until the frame ends
      train_pend_d = train_pend_q | train;

      if (!tx_start) begin
         state_d      = ST_DOWN;
         cnt_d        = '0;
         train_pend_d = 1'b0;
      end else begin
         case (state_q)
            ST_DOWN: begin
               state_d      = ST_TRAIN;
               cnt_d        = '0;
               train_pend_d = 1'b0;
            end
            ST_TRAIN: begin
               train_pend_d = 1'b0;
               if (cnt_q == CNT_LAST && cnt_q[1:0] == 2'b11 && !train) begin
                  state_d = ST_IDLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  // Hold in the last pattern group so the nibble sequence keeps cycling
                  cnt_d = CNT_WRAP;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            ST_IDLE, ST_CHK: begin
               if (xfer) begin
                  state_d = ST_SOF;
                  data_d  = din;
               end else if (train_pend_q || train) begin
                  state_d      = ST_TRAIN;
                  cnt_d        = '0;
                  train_pend_d = 1'b0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SOF: begin
               state_d = ST_DATA;
               cnt_d   = '0;
            end
            ST_DATA: begin
               if (cnt_q[1:0] == 2'b11) state_d = ST_CHK;
               cnt_d = cnt_q + CW'(1);
            end
            default: begin
               state_d = ST_DOWN;
               cnt_d   = '0;
            end
         endcase
      end

      // Outputs are precomputed from the next state so they register alongside it
      txd_d = 4'h0;
      case (state_d)
         ST_TRAIN: txd_d = train_nibble(cnt_d[1:0]);
         ST_IDLE:  txd_d = IDLE_NIB;
         ST_SOF:   txd_d = SOF_NIB;
         ST_DATA: begin
            case (cnt_d[1:0])
               2'd0:    txd_d = data_d[15:12];
               2'd1:    txd_d = data_d[11:8];
               2'd2:    txd_d = data_d[7:4];
               default: txd_d = data_d[3:0];
            endcase
         end
         ST_CHK:   txd_d = chk_nibble(data_d);
         default:  txd_d = 4'h0;
      endcase

      tx_ready_d  = (state_d != ST_DOWN) && (state_d != ST_TRAIN);
      din_ready_d = tx_start && !train_pend_d &&
                    ((state_d == ST_IDLE) || (state_d == ST_CHK));
   end

   always_ff @(posedge sclk or posedge rst_int) begin
      if (rst_int) begin
         state_q      <= ST_DOWN;
         cnt_q        <= '0;
         data_q       <= '0;
         train_pend_q <= 1'b0;
         txd_q        <= 4'h0;
         tx_ready_q   <= 1'b0;
         din_ready_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         data_q       <= data_d;
         train_pend_q <= train_pend_d;
         txd_q        <= txd_d;
         tx_ready_q   <= tx_ready_d;
         din_ready_q  <= din_ready_d;
      end
   end

   assign txd       = txd_q;
   assign tx_ready  = tx_ready_q;
   assign din_ready = din_ready_q;

endmodule

// File: tb/tb_serdes_tx_framer.sv
// Scoreboard bench for serdes_tx_framer with a short training length.
module tb_serdes_tx_framer;

   localparam int TL = 8;
   localparam logic [3:0] TPAT [4] = '{4'hF, 4'h0, 4'hC, 4'h3};

   logic        sclk = 1'b0;
   logic        reset;
   logic        tx_start;
   logic        train;
   logic [15:0] din;
   logic        din_valid;
   logic        din_ready;
   logic [3:0]  txd;
   logic        tx_ready;

   int errors = 0;
   int checks = 0;
   logic [11:0] exp_q [$];

   always #5 sclk = ~sclk;

   serdes_tx_framer #(.TRAIN_LEN(TL)) dut (
      .sclk      (sclk),
      .reset     (reset),
      .tx_start  (tx_start),
      .train     (train),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .txd       (txd),
      .tx_ready  (tx_ready)
   );

   // Packs {din_ready, tx_ready, txd} so each hex digit reads as one signal
   function automatic logic [11:0] pk(input logic dr, input logic tr, input logic [3:0] nib);
      return {3'b000, dr, 3'b000, tr, nib};
   endfunction

   task automatic push_train();
      for (int k = 0; k < TL; k++) exp_q.push_back(pk(1'b0, 1'b0, TPAT[k % 4]));
      exp_q.push_back(pk(1'b1, 1'b1, 4'hA));
   endtask

   task automatic push_frame(input logic [15:0] w, input logic chk_dr);
      exp_q.push_back(pk(1'b0, 1'b1, 4'h6));
      exp_q.push_back(pk(1'b0, 1'b1, w[15:12]));
      exp_q.push_back(pk(1'b0, 1'b1, w[11:8]));
      exp_q.push_back(pk(1'b0, 1'b1, w[7:4]));
      exp_q.push_back(pk(1'b0, 1'b1, w[3:0]));
      exp_q.push_back(pk(chk_dr, 1'b1, w[15:12] ^ w[11:8] ^ w[7:4] ^ w[3:0]));
   endtask

   task automatic test_reset();
      logic [11:0] got, e;
      bit found;
      reset = 1'b1; tx_start = 1'b1; train = 1'b0; din_valid = 1'b0; din = 16'h0;
      repeat (3) @(negedge sclk);
      got = pk(din_ready, tx_ready, txd);
      checks++;
      if (got !== pk(1'b0, 1'b0, 4'h0)) begin
         errors++; $display("FAIL reset_state got=%h exp=%h", got, pk(1'b0, 1'b0, 4'h0));
      end
      push_train();
      @(posedge sclk); #1 reset = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         @(negedge sclk);
         if (txd === 4'hF) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL reset_release got txd=%h exp=f within 12 cycles", txd);
         exp_q.delete();
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         if (i > 0) @(negedge sclk);
         got = pk(din_ready, tx_ready, txd);
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL train_seq[%0d] got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_single_frame();
      logic [11:0] got, e;
      push_frame(16'h1234, 1'b1);
      exp_q.push_back(pk(1'b1, 1'b1, 4'hA));
      @(posedge sclk); #1 din = 16'h1234; din_valid = 1'b1;
      @(posedge sclk); #1 din_valid = 1'b0; din = 16'hFFFF;
      for (int i = 0; exp_q.size() > 0; i++) begin
         @(negedge sclk);
         got = pk(din_ready, tx_ready, txd);
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL single_frame[%0d] got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] got, e;
      push_frame(16'hABCD, 1'b1);
      push_frame(16'h0000, 1'b1);
      exp_q.push_back(pk(1'b1, 1'b1, 4'hA));
      @(posedge sclk); #1 din = 16'hABCD; din_valid = 1'b1;
      @(posedge sclk); #1 din = 16'h0000; din_valid = 1'b1;
      for (int i = 0; exp_q.size() > 0; i++) begin
         if (i > 0) begin
            @(posedge sclk); #1 din_valid = (i < 6);
         end
         @(negedge sclk);
         got = pk(din_ready, tx_ready, txd);
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_train_midframe();
      logic [11:0] got, e, m;
      push_frame(16'h1234, 1'b0);
      push_train();
      @(posedge sclk); #1 din = 16'h1234; din_valid = 1'b1;
      @(posedge sclk); #1 din_valid = 1'b0;
      for (int i = 0; exp_q.size() > 0; i++) begin
         if (i > 0) begin
            @(posedge sclk); #1 train = (i == 3);
         end
         @(negedge sclk);
         got = pk(din_ready, tx_ready, txd);
         e = exp_q.pop_front();
         m = (i == 5) ? 12'h0FF : 12'hFFF;
         checks++;
         if ((got & m) !== (e & m)) begin
            errors++; $display("FAIL train_midframe[%0d] got=%h exp=%h", i, got, e);
         end
      end
   endtask

   task automatic test_txstart_drop();
      logic [11:0] got, e;
      exp_q.push_back(pk(1'b0, 1'b1, 4'h6));
      exp_q.push_back(pk(1'b0, 1'b1, 4'h1));
      exp_q.push_back(pk(1'b0, 1'b1, 4'h2));
      exp_q.push_back(pk(1'b0, 1'b0, 4'h0));
      exp_q.push_back(pk(1'b0, 1'b0, 4'h0));
      push_train();
      @(posedge sclk); #1 din = 16'h1234; din_valid = 1'b1;
      @(posedge sclk); #1 din_valid = 1'b0;
      for (int i = 0; exp_q.size() > 0; i++) begin
         if (i > 0) begin
            @(posedge sclk); #1 tx_start = !(i == 2 || i == 3);
         end
         @(negedge sclk);
         got = pk(din_ready, tx_ready, txd);
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL txstart_drop[%0d] got=%h exp=%h", i, got, e); end
      end
   endtask

   task automatic test_async_reset();
      logic [11:0] got, e;
      bit found;
      exp_q.push_back(pk(1'b0, 1'b1, 4'h6));
      exp_q.push_back(pk(1'b0, 1'b1, 4'hC));
      exp_q.push_back(pk(1'b0, 1'b1, 4'h3));
      @(posedge sclk); #1 din = 16'hC35A; din_valid = 1'b1;
      @(posedge sclk); #1 din_valid = 1'b0;
      for (int i = 0; exp_q.size() > 0; i++) begin
         @(negedge sclk);
         got = pk(din_ready, tx_ready, txd);
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL async_frame[%0d] got=%h exp=%h", i, got, e); end
      end
      @(posedge sclk); #3 reset = 1'b1; din = 16'hFFFF; din_valid = 1'b1;
      #1;
      got = pk(din_ready, tx_ready, txd);
      checks++;
      if (got !== pk(1'b0, 1'b0, 4'h0)) begin
         errors++; $display("FAIL async_assert got=%h exp=%h", got, pk(1'b0, 1'b0, 4'h0));
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge sclk);
         got = pk(din_ready, tx_ready, txd);
         checks++;
         if (got !== pk(1'b0, 1'b0, 4'h0)) begin
            errors++; $display("FAIL reset_hold[%0d] got=%h exp=%h", i, got, pk(1'b0, 1'b0, 4'h0));
         end
      end
      din_valid = 1'b0;
      push_train();
      @(posedge sclk); #1 reset = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         @(negedge sclk);
         if (txd === 4'hF) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL async_release got txd=%h exp=f within 12 cycles", txd);
         exp_q.delete();
      end
      for (int i = 0; exp_q.size() > 0; i++) begin
         if (i > 0) @(negedge sclk);
         got = pk(din_ready, tx_ready, txd);
         e = exp_q.pop_front();
         checks++;
         if (got !== e) begin errors++; $display("FAIL retrain_seq[%0d] got=%h exp=%h", i, got, e); end
      end
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_train_midframe();
      test_txstart_drop();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=completion");
      $fatal(1, "watchdog expired");
   end

endmodule
